// File: rtl/conv_mac_pipe.sv
// Pipelined multiplier / multiply-accumulate for the conv systolic-array PEs.
// Define CONV_MAC_SAT_EN to clamp results instead of wrapping them (drives o_sat).
module conv_mac_pipe #(
    parameter int unsigned A_WIDTH   = 11,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned P_WIDTH   = 11,
    parameter int unsigned A_SIGNED  = 1,
    parameter int unsigned B_SIGNED  = 0,
    parameter int unsigned NUM_STAGE = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic               i_in_valid,
    input  logic [A_WIDTH-1:0] i_din0,
    input  logic [B_WIDTH-1:0] i_din1,
    input  logic               i_acc_mode,
    input  logic               i_acc_first,
    output logic               o_dout_valid,
    output logic [P_WIDTH-1:0] o_dout,
    output logic               o_sat
);

    localparam int unsigned FULL     = A_WIDTH + B_WIDTH + 1;
    // Stage S2 plus the pure delay stages S3..S(N-1).
    localparam int unsigned NUM_PIPE = NUM_STAGE - 2;

    logic [A_WIDTH-1:0]  r_s1_a;
    logic [B_WIDTH-1:0]  r_s1_b;
    logic                r_s1_vld;
    logic                r_s1_mode;
    logic                r_s1_first;

    logic [FULL-1:0]     r_prod [NUM_PIPE];
    logic [NUM_PIPE-1:0] r_vld;
    logic [NUM_PIPE-1:0] r_mode;
    logic [NUM_PIPE-1:0] r_first;

    logic [P_WIDTH-1:0]  r_acc;
    logic [P_WIDTH-1:0]  r_dout;
    logic                r_dout_valid;
    logic                r_sat;

    logic [FULL-1:0]     w_a_ext;
    logic [FULL-1:0]     w_b_ext;
    logic [FULL-1:0]     w_prod;
    logic [FULL-1:0]     w_last_prod;
    logic                w_last_vld;
    logic                w_last_mode;
    logic                w_last_first;
    logic [P_WIDTH-1:0]  w_p;
    logic                w_p_sat;
    logic [P_WIDTH-1:0]  w_sum;
    logic                w_sum_sat;
    logic [P_WIDTH-1:0]  w_res;
    logic                w_sat;

    assign w_a_ext = {{(FULL-A_WIDTH){(A_SIGNED != 0) & r_s1_a[A_WIDTH-1]}}, r_s1_a};
    assign w_b_ext = {{(FULL-B_WIDTH){(B_SIGNED != 0) & r_s1_b[B_WIDTH-1]}}, r_s1_b};
    // Low FULL bits of the product are exact for every signedness combination.
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_first <= 1'b0;
            r_vld      <= '0;
            r_mode     <= '0;
            r_first    <= '0;
            for (int i = 0; i < int'(NUM_PIPE); i++) begin
                r_prod[i] <= '0;
            end
        end else if (i_ce) begin
            r_s1_a     <= i_din0;
            r_s1_b     <= i_din1;
            r_s1_vld   <= i_in_valid;
            r_s1_mode  <= i_acc_mode;
            r_s1_first <= i_acc_first;
            r_prod[0]  <= w_prod;
            r_vld[0]   <= r_s1_vld;
            r_mode[0]  <= r_s1_mode;
            r_first[0] <= r_s1_first;
            for (int i = 1; i < int'(NUM_PIPE); i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_vld[i]   <= r_vld[i-1];
                r_mode[i]  <= r_mode[i-1];
                r_first[i] <= r_first[i-1];
            end
        end
    end

    assign w_last_prod  = r_prod[NUM_PIPE-1];
    assign w_last_vld   = r_vld[NUM_PIPE-1];
    assign w_last_mode  = r_mode[NUM_PIPE-1];
    assign w_last_first = r_first[NUM_PIPE-1];

`ifdef CONV_MAC_SAT_EN
    localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam logic [P_WIDTH-1:0] MAX_S = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] MIN_S = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic [FULL-1:0]  w_hi;
    logic [P_WIDTH:0] w_sum_ext;

    // Signed product fits iff everything from bit P_WIDTH-1 upward is a sign copy.
    assign w_hi = FULL'($signed(w_last_prod) >>> (P_WIDTH-1));

    always_comb begin
        w_p       = w_last_prod[P_WIDTH-1:0];
        w_p_sat   = 1'b0;
        w_sum_ext = '0;
        w_sum     = '0;
        w_sum_sat = 1'b0;
        if (RES_SIGNED) begin
            if ((w_hi != '0) && (w_hi != '1)) begin
                w_p_sat = 1'b1;
                w_p     = w_last_prod[FULL-1] ? MIN_S : MAX_S;
            end
            w_sum_ext = {r_acc[P_WIDTH-1], r_acc} + {w_p[P_WIDTH-1], w_p};
            w_sum     = w_sum_ext[P_WIDTH-1:0];
            if (w_sum_ext[P_WIDTH] != w_sum_ext[P_WIDTH-1]) begin
                w_sum_sat = 1'b1;
                w_sum     = w_sum_ext[P_WIDTH] ? MIN_S : MAX_S;
            end
        end else begin
            if ((w_last_prod >> P_WIDTH) != '0) begin
                w_p_sat = 1'b1;
                w_p     = '1;
            end
            w_sum_ext = {1'b0, r_acc} + {1'b0, w_p};
            w_sum     = w_sum_ext[P_WIDTH-1:0];
            if (w_sum_ext[P_WIDTH]) begin
                w_sum_sat = 1'b1;
                w_sum     = '1;
            end
        end
    end
`else
    logic w_unused_hi;

    assign w_unused_hi = ^w_last_prod[FULL-1:P_WIDTH];
    assign w_p         = w_last_prod[P_WIDTH-1:0];
    assign w_p_sat     = 1'b0;
    assign w_sum       = r_acc + w_p;
    assign w_sum_sat   = 1'b0;
`endif

    always_comb begin
        w_res = w_p;
        w_sat = w_p_sat;
        if (w_last_mode && !w_last_first) begin
            w_res = w_sum;
            w_sat = w_p_sat | w_sum_sat;
        end
    end

    // Invalid beats leave dout, sat and the accumulator untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_sat        <= 1'b0;
            r_acc        <= '0;
        end else if (i_ce) begin
            r_dout_valid <= w_last_vld;
            if (w_last_vld) begin
                r_dout <= w_res;
                r_sat  <= w_sat;
                if (w_last_mode) begin
                    r_acc <= w_res;
                end
            end
        end
    end

    assign o_dout_valid = r_dout_valid;
    assign o_dout       = r_dout;
    assign o_sat        = r_sat;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed, scoreboard-based bench for conv_mac_pipe at default parameters.
// Honours CONV_MAC_SAT_EN in its reference model.
module tb_conv_mac_pipe;

    localparam int NUM_STAGE = 4;

    typedef struct {
        logic [10:0] d;
        logic        s;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [10:0] din0;
    logic [7:0]  din1;
    logic        acc_mode;
    logic        acc_first;
    logic        dout_valid;
    logic [10:0] dout;
    logic        sat;

    int          checks = 0;
    int          errors = 0;
    int          ce_cnt = 0;
    logic        ce_edge = 1'b0;
    logic        rst_edge = 1'b1;
    logic [10:0] m_acc = '0;
    logic [10:0] last_d = '0;
    logic        last_s = 1'b0;
    logic [10:0] fz_d;
    logic        fz_v;
    logic        fz_s;
    exp_t        sb_q[$];

    conv_mac_pipe u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ce        (ce),
        .i_in_valid  (in_valid),
        .i_din0      (din0),
        .i_din1      (din1),
        .i_acc_mode  (acc_mode),
        .i_acc_first (acc_first),
        .o_dout_valid(dout_valid),
        .o_dout      (dout),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_edge  <= ce;
        rst_edge <= reset;
        if (ce && !reset) ce_cnt <= ce_cnt + 1;
    end

    task automatic model(input int a, input int b, input logic mode, input logic first,
                         output logic [10:0] d, output logic s);
        int          prod;
        int          p;
        int          sum;
        logic [31:0] pv;
        prod = a * b;
        s    = 1'b0;
`ifdef CONV_MAC_SAT_EN
        p = prod;
        if (p > 1023) begin p = 1023; s = 1'b1; end
        else if (p < -1024) begin p = -1024; s = 1'b1; end
        if (mode && !first) begin
            sum = int'($signed(m_acc)) + p;
            if (sum > 1023) begin sum = 1023; s = 1'b1; end
            else if (sum < -1024) begin sum = -1024; s = 1'b1; end
            p = sum;
        end
        pv = p;
        d  = pv[10:0];
`else
        pv = prod;
        d  = pv[10:0];
        if (mode && !first) d = d + m_acc;
`endif
        if (mode) m_acc = d;
    endtask

    task automatic beat(input int a, input int b, input logic v, input logic mode,
                        input logic first);
        exp_t e;
        in_valid  = v;
        din0      = 11'(a);
        din1      = 8'(b);
        acc_mode  = mode;
        acc_first = first;
        if (v) begin
            model(a, b, mode, first, e.d, e.s);
            e.due = ce_cnt + NUM_STAGE;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        assert (dout_valid === 1'b0) else begin
            errors++; $error("FAIL %s_valid observed=%b expected=0", tag, dout_valid);
        end
        checks++;
        assert (dout === 11'h000) else begin
            errors++; $error("FAIL %s_dout observed=%h expected=000", tag, dout);
        end
        checks++;
        assert (sat === 1'b0) else begin
            errors++; $error("FAIL %s_sat observed=%b expected=0", tag, sat);
        end
    endtask

    // Output monitor: pops on every ce-edge beat, checks holds across bubbles.
    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            last_d = '0;
            last_s = 1'b0;
        end else if (ce_edge) begin
            if (dout_valid) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++; $error("FAIL unexpected_beat observed dout=%h expected none", dout);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    assert (dout === e.d) else begin
                        errors++; $error("FAIL dout observed=%h expected=%h", dout, e.d);
                    end
                    checks++;
                    assert (sat === e.s) else begin
                        errors++; $error("FAIL sat observed=%b expected=%b", sat, e.s);
                    end
                    checks++;
                    assert (ce_cnt === e.due) else begin
                        errors++; $error("FAIL latency observed_edge=%0d expected_edge=%0d",
                                         ce_cnt, e.due);
                    end
                    last_d = e.d;
                    last_s = e.s;
                end
            end else begin
                checks++;
                assert (dout === last_d && sat === last_s) else begin
                    errors++; $error("FAIL bubble_hold observed=%h/%b expected=%h/%b",
                                     dout, sat, last_d, last_s);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
        acc_mode = 1'b0; acc_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_init");
        reset = 1'b0;
        idle(2);

        // Plain multiply, overflow/wrap-or-clamp.
        beat(-3, 200, 1'b1, 1'b0, 1'b0);
        idle(5);
        beat(1023, 255, 1'b1, 1'b0, 1'b0);
        beat(-1024, 255, 1'b1, 1'b0, 1'b0);
        beat(-1024, 0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Accumulate, then again with a mode-0 beat wedged in.
        beat(2, 3, 1'b1, 1'b1, 1'b1);
        beat(4, 5, 1'b1, 1'b1, 1'b0);
        beat(-1, 10, 1'b1, 1'b1, 1'b0);
        idle(2);
        beat(2, 3, 1'b1, 1'b1, 1'b1);
        beat(4, 5, 1'b1, 1'b1, 1'b0);
        beat(7, 1, 1'b1, 1'b0, 1'b1);
        beat(-1, 10, 1'b1, 1'b1, 1'b0);
        beat(1000, 200, 1'b1, 1'b1, 1'b0);
        idle(5);

        // ce stall after beat 3.
        for (int k = 1; k <= 3; k++) beat(k, 1, 1'b1, 1'b0, 1'b0);
        fz_d = dout; fz_v = dout_valid; fz_s = sat;
        ce = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            assert (dout === fz_d && dout_valid === fz_v && sat === fz_s) else begin
                errors++; $error("FAIL stall_freeze observed=%h/%b expected=%h/%b",
                                 dout, dout_valid, fz_d, fz_v);
            end
        end
        ce = 1'b1;
        for (int k = 4; k <= 6; k++) beat(k, 1, 1'b1, 1'b0, 1'b0);
        idle(6);

        // Reset with three beats in flight.
        beat(3, 3, 1'b1, 1'b1, 1'b1);
        beat(1, 1, 1'b1, 1'b1, 1'b0);
        beat(2, 2, 1'b1, 1'b1, 1'b0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("reset_mid");
        sb_q.delete();
        m_acc = '0;
        reset = 1'b0;
        idle(5);
        beat(5, 5, 1'b1, 1'b1, 1'b0);
        idle(5);

        // Bubbles.
        for (int k = 1; k <= 6; k++) beat(k, 2, logic'(k % 2), 1'b0, 1'b0);
        idle(6);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++; $error("FAIL drain observed_pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
